mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares one unified single-port memory between two pipeline requesters:
  - instruction fetch (I port);
  - the MEM-stage data access (D port).
- Three-state grant FSM, one outstanding memory transaction, registered completion, access watchdog.
- Sits between the core's Instr/ReadData/WriteData/MemWrite boundary and a shared memory with a Req/Ack handshake.
- The hazard unit stalls IF and MEM stages while their port's Ready is low.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles MemReq may stay high without MemAck (1..255)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- IReq  in  1  instruction read request; level, held until IReady
- IAddr  in  ADDR_W  fetch address; stable while IReq
- IReady  out  1  one-cycle completion pulse for I port
- IRData  out  DATA_W  fetched word, valid when IReady
- DReq  in  1  data request; level, held until DReady
- DWE  in  1  1 = write, 0 = read; stable while DReq
- DAddr  in  ADDR_W  data address
- DWData  in  DATA_W  store data
- DReady  out  1  one-cycle completion pulse for D port
- DRData  out  DATA_W  load data, valid when DReady on a read
- MemReq  out  1  memory request, level
- MemWE  out  1  memory write enable, qualified by MemReq
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemAck  in  1  memory completion, one-cycle pulse
- MemRData  in  DATA_W  memory read data, valid with MemAck
- Err  out  1  one-cycle pulse: transaction ended by timeout
- ErrSticky  out  1  set on any timeout; cleared only by Reset

## Operation
FSM states: IDLE, I_WAIT, D_WAIT.

- **Reset values:** state IDLE; all outputs 0; IRData and DRData 0; watchdog 0.
- **IDLE arbitration:**
  - A port is eligible if its Req=1 and its Ready output is 0 this cycle. This absorbs the cycle in which the requester drops Req.
  - Both eligible → D wins. This is the default priority; see Configuration.
  - On grant: register Addr/WE/WData into MemAddr/MemWE/MemWData, set MemReq=1, enter the matching WAIT state.
  - I grant forces MemWE=0.
- **WAIT states:**
  - MemReq held at 1 and Mem* fields held stable.
  - Watchdog increments each cycle.
  - On MemAck: MemReq→0, MemWE→0, return to IDLE, pulse the granted port's Ready next cycle.
  - Read: capture MemRData into IRData/DRData.
  - Write: DRData holds its previous value.
- **Timeout:** watchdog reaches TIMEOUT with no MemAck →
  - complete the transaction as if acked;
  - RData captured as 0;
  - Err pulses with Ready;
  - ErrSticky set.
- **MemAck in IDLE:** ignored.
- IRData/DRData retain their values between transactions.
- The arbiter does not register or consume Req edges; requests are levels sampled only in IDLE.

## Timing
- Grant decision in cycle k → MemReq high from cycle k+1.
- MemAck in cycle k+1+L (L≥0) → Ready, RData and Err valid in cycle k+2+L. The FSM is in IDLE that same cycle.
- Minimum transaction: 2 cycles request-to-Ready.
- Next grant to the other port can occur in the Ready cycle, giving MemReq again at k+3+L. Same-port regrant is blocked that cycle.
- Reset mid-transaction: MemReq drops immediately (asynchronous). No Ready or Err is issued for the aborted access.
- Watchdog cleared on every grant; Err and Ready asserted together.

## Configuration
- MEM_ARB_RR_EN defined: round-robin priority. On simultaneous eligibility, the port not granted last wins. The last-granted flag resets to "I", so D wins the first tie.
- Undefined: fixed D-over-I priority. A continuously requesting D port may starve I.

## Test plan
- Single fetch, IAddr=0x10, memory acks 3 cycles after MemReq rises → MemAddr=0x10, MemWE=0; IReady pulse 4 cycles after MemReq rise with IRData=MemRData=0xE3A00001.
- Simultaneous IReq+DReq (DWE=1, DAddr=0x80, DWData=0x55) with MEM_ARB_RR_EN undefined:
  - D served first (MemWE=1, MemWData=0x55);
  - I granted in the DReady cycle;
  - DRData unchanged.
- Same as above with MEM_ARB_RR_EN defined and D served last: I granted first, then D.
- No MemAck, TIMEOUT=4 → MemReq high exactly 4 cycles; DReady, Err and DRData=0 the next cycle; ErrSticky stays 1 until Reset.
- Reset asserted in D_WAIT → MemReq=0, DReady=0, state IDLE at once; after release, a new IReq is granted normally.
- Stray MemAck in IDLE plus back-to-back IReq held through IReady → no spurious Ready; the second fetch is granted the cycle after IReady.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data access) arbiter in front of one single-port memory.
// Optional round-robin tie-break is enabled by defining MEM_ARB_RR_EN; otherwise D has fixed priority over I.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              IReq,
   input  logic [ADDR_W-1:0] IAddr,
   output logic              IReady,
   output logic [DATA_W-1:0] IRData,
   input  logic              DReq,
   input  logic              DWE,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [DATA_W-1:0] DWData,
   output logic              DReady,
   output logic [DATA_W-1:0] DRData,
   output logic              MemReq,
   output logic              MemWE,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic              MemAck,
   input  logic [DATA_W-1:0] MemRData,
   output logic              Err,
   output logic              ErrSticky
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_WAIT = 2'd1,
      D_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   state_t              r_state,      w_state;
   logic                r_mem_req,    w_mem_req;
   logic                r_mem_we,     w_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata;
   logic                r_iready,     w_iready;
   logic                r_dready,     w_dready;
   logic [DATA_W-1:0]   r_irdata,     w_irdata;
   logic [DATA_W-1:0]   r_drdata,     w_drdata;
   logic                r_err,        w_err;
   logic                r_err_sticky, w_err_sticky;
   logic [7:0]          r_wd,         w_wd;

   logic                w_i_elig;
   logic                w_d_elig;
   logic                w_pick_d;
   logic [7:0]          w_wd_inc;
   logic                w_timeout;
   logic [DATA_W-1:0]   w_rdata_cap;

   // A port whose Ready is high this cycle is still dropping its request, so it is not eligible.
   assign w_i_elig = IReq && !r_iready;
   assign w_d_elig = DReq && !r_dready;

`ifdef MEM_ARB_RR_EN
   logic r_last_d, w_last_d;

   assign w_pick_d = w_d_elig && (!w_i_elig || !r_last_d);

   always_comb begin
      w_last_d = r_last_d;
      if (r_state == IDLE) begin
         if (w_pick_d) begin
            w_last_d = 1'b1;
         end else if (w_i_elig) begin
            w_last_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_last_d <= 1'b0;
      end else begin
         r_last_d <= w_last_d;
      end
   end
`else
   assign w_pick_d = w_d_elig;
`endif

   always_comb begin
      w_state      = r_state;
      w_mem_req    = r_mem_req;
      w_mem_we     = r_mem_we;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      w_iready     = 1'b0;
      w_dready     = 1'b0;
      w_irdata     = r_irdata;
      w_drdata     = r_drdata;
      w_err        = 1'b0;
      w_err_sticky = r_err_sticky;
      w_wd         = r_wd;
      w_wd_inc     = r_wd + 8'd1;
      w_timeout    = 1'b0;
      w_rdata_cap  = '0;

      case (r_state)
         IDLE: begin
            if (w_pick_d) begin
               w_state     = D_WAIT;
               w_mem_req   = 1'b1;
               w_mem_we    = DWE;
               w_mem_addr  = DAddr;
               w_mem_wdata = DWData;
               w_wd        = '0;
            end else if (w_i_elig) begin
               w_state     = I_WAIT;
               w_mem_req   = 1'b1;
               w_mem_we    = 1'b0;
               w_mem_addr  = IAddr;
               w_wd        = '0;
            end
         end

         I_WAIT, D_WAIT: begin
            // An ack arriving on the last allowed cycle wins over the timeout.
            w_timeout = !MemAck && (w_wd_inc == TO_LIMIT);
            if (MemAck || w_timeout) begin
               w_state     = IDLE;
               w_mem_req   = 1'b0;
               w_mem_we    = 1'b0;
               w_err       = w_timeout;
               w_rdata_cap = MemAck ? MemRData : '0;
               if (w_timeout) begin
                  w_err_sticky = 1'b1;
               end
               if (r_state == I_WAIT) begin
                  w_iready = 1'b1;
                  w_irdata = w_rdata_cap;
               end else begin
                  w_dready = 1'b1;
                  if (!r_mem_we) begin
                     w_drdata = w_rdata_cap;
                  end
               end
            end else begin
               w_wd = w_wd_inc;
            end
         end

         default: begin
            w_state   = IDLE;
            w_mem_req = 1'b0;
            w_mem_we  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_iready     <= 1'b0;
         r_dready     <= 1'b0;
         r_irdata     <= '0;
         r_drdata     <= '0;
         r_err        <= 1'b0;
         r_err_sticky <= 1'b0;
         r_wd         <= '0;
      end else begin
         r_state      <= w_state;
         r_mem_req    <= w_mem_req;
         r_mem_we     <= w_mem_we;
         r_mem_addr   <= w_mem_addr;
         r_mem_wdata  <= w_mem_wdata;
         r_iready     <= w_iready;
         r_dready     <= w_dready;
         r_irdata     <= w_irdata;
         r_drdata     <= w_drdata;
         r_err        <= w_err;
         r_err_sticky <= w_err_sticky;
         r_wd         <= w_wd;
      end
   end

   assign MemReq    = r_mem_req;
   assign MemWE     = r_mem_we;
   assign MemAddr   = r_mem_addr;
   assign MemWData  = r_mem_wdata;
   assign IReady    = r_iready;
   assign IRData    = r_irdata;
   assign DReady    = r_dready;
   assign DRData    = r_drdata;
   assign Err       = r_err;
   assign ErrSticky = r_err_sticky;

endmodule
